// File: rtl/swv_run_sequencer.sv
// Run sequencer for the square-wave-voltammetry engine: shadows the 7-word parameter
// frame, loads it serially, fires start and repeats runs while watching the shield bus.
module swv_run_sequencer #(
    parameter int GAP_CYCLES  = 16,
    parameter int ACT_TIMEOUT = 255
) (
    input  logic        ti_clk,
    input  logic        rst_n,
    input  logic        host_wr,
    input  logic [2:0]  host_addr,
    input  logic [15:0] host_data,
    input  logic        go,
    input  logic        abort,
    input  logic [7:0]  eng_shield,
    output logic        eng_rst,
    output logic [15:0] eng_data_in,
    output logic        eng_data_update_trig,
    output logic        eng_start_trig,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        err_timeout,
    output logic        wr_reject,
    output logic [7:0]  run_index
);
    typedef enum logic [2:0] {IDLE, RST, LOAD, START, WAIT_ACT, WAIT_DONE, GAP, ABORT} state_t;

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] ACT_LAST = 16'(ACT_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  word_q, word_d;
    logic [1:0]  phase_q, phase_d;
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_fire, done_fire, run_inc;

    logic [15:0] frame [0:6];
    logic [7:0]  rep, rep_eff, run_next;
    logic [7:0]  shield_meta, shield_sync;
    logic        shield_act, shield_idle, go_accept;

    logic        eng_rst_d, trig_d, start_d;
    logic [15:0] data_d;

    assign rep_eff     = (rep == 8'd0) ? 8'd1 : rep;
    assign run_next    = run_index + 8'd1;
    assign shield_act  = (shield_sync == 8'hFF);
    assign shield_idle = (shield_sync == 8'h00);
    assign go_accept   = (state_q == IDLE) && go;

    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 7; i++) frame[i] <= '0;
            rep <= '0;
        end else if (host_wr && state_q == IDLE) begin
            if (host_addr == 3'd7) rep <= host_data[7:0];
            else                   frame[host_addr] <= host_data;
        end
    end

    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            phase_q     <= '0;
            cnt_q       <= '0;
            shield_meta <= '0;
            shield_sync <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            shield_meta <= eng_shield;
            shield_sync <= shield_meta;
        end
    end

    // Abort outranks every other transition once a sequence is in flight.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        timeout_fire = 1'b0;
        done_fire    = 1'b0;
        run_inc      = 1'b0;
        if (state_q != IDLE && abort) begin
            state_d = ABORT;
        end else begin
            case (state_q)
                IDLE: if (go) state_d = RST;
                RST: begin
                    state_d = LOAD;
                    word_d  = '0;
                    phase_d = '0;
                end
                LOAD: begin
                    if (phase_q == 2'd2) begin
                        phase_d = '0;
                        if (word_q == 3'd6) begin
                            state_d = START;
                            cnt_d   = '0;
                        end else begin
                            word_d = word_q + 3'd1;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
                START: begin
                    if (cnt_q == 16'd1) begin
                        state_d = WAIT_ACT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                WAIT_ACT: begin
                    if (shield_act) begin
                        state_d = WAIT_DONE;
                    end else if (cnt_q == ACT_LAST) begin
                        state_d      = IDLE;
                        timeout_fire = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (shield_idle) begin
                        run_inc = 1'b1;
                        if (run_next == rep_eff) begin
                            state_d   = IDLE;
                            done_fire = 1'b1;
                        end else begin
                            state_d = GAP;
                            cnt_d   = '0;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = START;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ABORT:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes are decoded from the upcoming state so the registered outputs line up with it.
    always_comb begin
        eng_rst_d = 1'b0;
        data_d    = '0;
        trig_d    = 1'b0;
        start_d   = 1'b0;
        case (state_d)
            RST, ABORT: eng_rst_d = 1'b1;
            LOAD: begin
                data_d = frame[word_d];
                trig_d = (phase_d == 2'd1);
            end
            START:   start_d = 1'b1;
            default: ;
        endcase
        if (timeout_fire) eng_rst_d = 1'b1;
    end

    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_rst              <= 1'b0;
            eng_data_in          <= '0;
            eng_data_update_trig <= 1'b0;
            eng_start_trig       <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            aborted              <= 1'b0;
            err_timeout          <= 1'b0;
            wr_reject            <= 1'b0;
            run_index            <= '0;
        end else begin
            eng_rst              <= eng_rst_d;
            eng_data_in          <= data_d;
            eng_data_update_trig <= trig_d;
            eng_start_trig       <= start_d;
            busy                 <= (state_d != IDLE);
            done                 <= done_fire;
            aborted              <= (state_q == ABORT) && (state_d == IDLE);
            wr_reject            <= host_wr && (state_q != IDLE);
            if (go_accept) begin
                run_index   <= '0;
                err_timeout <= 1'b0;
            end else begin
                if (run_inc)      run_index   <= run_next;
                if (timeout_fire) err_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: doc/swv_run_sequencer.md
# swv_run_sequencer

Controller for the square-wave-voltammetry DAC engine. It holds a host-written shadow copy of the engine's 7-word parameter frame (ADC ref, E_init, E_raise, E_fall, time_max hi/lo, step_max) and serially loads it into the engine's `data_in`/`data_update_trig` port. It then fires `start_trig` and tracks engine activity through the shield bus, repeating the run a programmable number of times. It sits between the host register interface and the engine, and replaces direct host toggling of the engine's trigger wires.

## Interface
- `GAP_CYCLES`, 16: idle ti_clk cycles between consecutive runs (1..65535).
- `ACT_TIMEOUT`, 255: cycles allowed after start for the engine to report active (1..255).

- `ti_clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `host_wr`  in  1  single-cycle write strobe.
- `host_addr`  in  3  0..6 = frame word 0..6; 7 = repeat count (`host_data[7:0]`).
- `host_data`  in  16  write data.
- `go`  in  1  single-cycle start request.
- `abort`  in  1  single-cycle abort request.
- `eng_shield`  in  8  engine shield bus: 8'hFF = running, 8'h00 = idle.
- `eng_rst`  out  1  active-high engine reset pulse.
- `eng_data_in`  out  16  frame word to engine.
- `eng_data_update_trig`  out  1  engine word-load strobe.
- `eng_start_trig`  out  1  engine start strobe.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when all runs complete.
- `aborted`  out  1  one-cycle pulse on abort completion.
- `err_timeout`  out  1  sticky; cleared by the next accepted `go`.
- `wr_reject`  out  1  one-cycle pulse when a host write is ignored.
- `run_index`  out  8  completed runs in the current sequence.

## Operation
- Shadow bank: 7×16 frame registers plus an 8-bit `rep`, all reset to 0.
  - A write is applied only when `busy`=0. A write while busy is dropped and raises `wr_reject` the next cycle.
  - `rep`=0 is treated as 1.
- FSM states: IDLE, RST, LOAD, START, WAIT_ACT, WAIT_DONE, GAP, ABORT.
- IDLE:
  - `go` moves to RST, clears `run_index` and `err_timeout`.
  - `abort` in IDLE is ignored.
  - A host write in the same cycle as `go` is applied, and the load uses the new value.
- RST: `eng_rst`=1 for one cycle, which realigns the engine's word pointer. Then LOAD with k=0.
- LOAD: three cycles per word k=0..6.
  - Phase A: `eng_data_in`=word[k], trig=0.
  - Phase B: trig=1.
  - Phase C: trig=0.
  - `eng_data_in` holds word[k] through all three phases. After k=6 phase C, go to START.
- START: `eng_start_trig`=1 for two cycles, then WAIT_ACT with the timeout counter cleared.
- WAIT_ACT:
  - `eng_shield`==8'hFF moves to WAIT_DONE.
  - If the counter reaches ACT_TIMEOUT first: set `err_timeout`, pulse `eng_rst`, return to IDLE. No `done` is issued.
- WAIT_DONE:
  - Waits, unbounded, for `eng_shield`==8'h00, then increments `run_index`.
  - If the new `run_index`==max(`rep`,1): pulse `done`, go to IDLE.
  - Otherwise go to GAP.
- GAP: counts GAP_CYCLES, then START. There is no reload; the engine retains its frame.
- Abort:
  - `abort` in any non-IDLE state moves to ABORT next cycle, with priority over all other transitions.
  - ABORT drives `eng_rst`=1 for one cycle and all other strobes 0. Next cycle: IDLE, `aborted` pulses, `run_index` is held.
- `go` while busy is ignored.
- `run_index` increments at most 255; `rep`=255 completes exactly at 255, with no wrap.
- Shield values other than 8'h00/8'hFF count as neither active nor idle.

## Timing
- Reset values: all outputs 0. FSM in IDLE, counters 0, shadow bank 0.
- All outputs are registered.
- `go` sampled at edge 0:
  - `busy` and `eng_rst` high in cycle 1.
  - Word k data valid from cycle 2+3k; trig high in cycle 3+3k (last trig in cycle 21).
  - `eng_start_trig` high in cycles 23–24.
  - WAIT_ACT begins in cycle 25.
- `eng_shield` is sampled through a 2-flop synchronizer, since the engine runs on negedge. Detection latency is 2–3 cycles.
- From shield idle detection: `done` follows 1 cycle later; the next `eng_start_trig` follows GAP_CYCLES+1 cycles later.
- Abort latency: `eng_rst` asserted 1 cycle after `abort`; `aborted` 2 cycles after.
- Async reset mid-load drops all strobes immediately. No partial frame is replayed.

## Test plan
- Write words 0x0800,0x0100,0x0010,0xFFF0,0x0000,0x03E8,0x000A with `rep`=1; `go` → `eng_rst` in cycle 1, seven trig pulses in cycles 3,6,…,21 carrying those values; start in cycles 23–24. Model shield FF then 00 → `done` pulse, `run_index`=1.
- `rep`=3, GAP_CYCLES=16 → three start bursts, each 17 cycles after shield-idle detection; single `done`; `run_index`=3.
- Shield held 00 after start → `err_timeout`=1 after 255 cycles, `eng_rst` pulse, `busy`=0, no `done`. Next `go` clears `err_timeout`.
- `abort` during LOAD word 4 → `eng_rst` next cycle, no further trig; `aborted` 2 cycles after; `go` then reloads all 7 words.
- Host write addr 2 while busy → `wr_reject` pulse, shadow unchanged. Write plus `go` in the same IDLE cycle → new value loaded.
- `rep`=0 → exactly one run; `go` during WAIT_DONE ignored; `rst_n` low mid-WAIT_DONE → all outputs 0 asynchronously.
